// File: rtl/instr_packer.sv
`default_nettype none
// ============================================================================
// Module      : instr_packer
// Description : Two-stage valid/ready pipeline that packs a sign-extended
//               immediate and register fields into a 32-bit instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immsrc,
  input  logic [31:0]      immval,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0]       c_fmt_i   = 3'b000;
  localparam logic [2:0]       c_fmt_s   = 3'b001;
  localparam logic [2:0]       c_fmt_b   = 3'b010;
  localparam logic [2:0]       c_fmt_j   = 3'b011;
  localparam logic [2:0]       c_fmt_u   = 3'b100;
  localparam logic [31:0]      c_nop     = 32'h0000_0013;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic             r_s1_valid;
  logic [2:0]       r_s1_immsrc;
  logic [31:0]      r_s1_imm;
  logic [6:0]       r_s1_opcode;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [2:0]       r_s1_funct3;
  logic             r_s1_err;
  logic             r_s2_valid;
  logic [31:0]      r_instr;
  logic             r_err;
  logic [CNT_W-1:0] r_pkt_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_s1_adv;
  logic             w_accept;
  logic             w_deliver;
  logic             w_sext11;
  logic             w_sext12;
  logic             w_sext20;
  logic             w_in_err;
  logic [31:0]      w_asm;

  assign w_s1_adv  = !r_s2_valid || out_ready;
  // Gated by rst so the block advertises no space while held in reset.
  assign in_ready  = !rst && (!r_s1_valid || w_s1_adv);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = r_s2_valid && out_ready;

  assign out_valid = r_s2_valid;
  assign instr     = r_instr;
  assign out_err   = r_err;
  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;

  assign w_sext11 = (&immval[31:11]) || !(|immval[31:11]);
  assign w_sext12 = (&immval[31:12]) || !(|immval[31:12]);
  assign w_sext20 = (&immval[31:20]) || !(|immval[31:20]);

  always_comb begin
    w_in_err = 1'b1;
    case (immsrc)
      c_fmt_i: w_in_err = !w_sext11;
      c_fmt_s: w_in_err = !w_sext11;
      c_fmt_b: w_in_err = !w_sext12 || immval[0];
      c_fmt_j: w_in_err = !w_sext20 || immval[0];
      c_fmt_u: w_in_err = |immval[11:0];
      default: w_in_err = 1'b1;
    endcase
  end

  // Out-of-range immediates still produce the truncated encoding.
  always_comb begin
    w_asm = c_nop;
    case (r_s1_immsrc)
      c_fmt_i: w_asm = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      c_fmt_s: w_asm = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                        r_s1_imm[4:0], r_s1_opcode};
      c_fmt_b: w_asm = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                        r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
      c_fmt_j: w_asm = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                        r_s1_rd, r_s1_opcode};
      c_fmt_u: w_asm = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
      default: w_asm = c_nop;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_immsrc <= 3'b000;
      r_s1_imm    <= 32'h0;
      r_s1_opcode <= 7'h0;
      r_s1_rd     <= 5'h0;
      r_s1_rs1    <= 5'h0;
      r_s1_rs2    <= 5'h0;
      r_s1_funct3 <= 3'h0;
      r_s1_err    <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_immsrc <= immsrc;
        r_s1_imm    <= immval;
        r_s1_opcode <= opcode;
        r_s1_rd     <= rd;
        r_s1_rs1    <= rs1;
        r_s1_rs2    <= rs2;
        r_s1_funct3 <= funct3;
        r_s1_err    <= w_in_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_instr    <= 32'h0;
      r_err      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr <= w_asm;
        r_err   <= r_s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else if (w_deliver) begin
      if (r_pkt_count != '1) begin
        r_pkt_count <= r_pkt_count + c_cnt_one;
      end
      if (r_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + c_cnt_one;
      end
    end
  end

  // Unused in the accept path but kept visible for debug probes.
  logic w_unused;
  assign w_unused = w_accept;

endmodule
`default_nettype wire

// File: tb/tb_instr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_packer
// Description : Self-checking bench for instr_packer with a scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  immsrc = 3'b0;
  logic [31:0] immval = 32'h0;
  logic [6:0]  opcode = 7'h0;
  logic [4:0]  rd = 5'h0;
  logic [4:0]  rs1 = 5'h0;
  logic [4:0]  rs2 = 5'h0;
  logic [2:0]  funct3 = 3'h0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] instr;
  logic [15:0] pkt_count, err_count;
  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] instr2;
  logic [1:0]  pkt_count2, err_count2;

  always #5 clk = ~clk;

  instr_packer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .immval(immval), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .out_err(out_err), .pkt_count(pkt_count), .err_count(err_count)
  );

  instr_packer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .immsrc(immsrc), .immval(immval), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .out_valid(out_valid2), .out_ready(out_ready),
    .instr(instr2), .out_err(out_err2), .pkt_count(pkt_count2), .err_count(err_count2)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  src;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_passed = 0;
  int   m_pkt = 0;
  int   m_err = 0;
  int   m_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? 32'(maxv) : 32'(v);
  endfunction

  // Reference: legality from the signed value range of each format.
  function automatic logic model_err(input logic [2:0] src, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (src)
      3'd0, 3'd1: return !(v >= -2048 && v <= 2047);
      3'd2:       return !(v >= -4096 && v <= 4095) || (v % 2 != 0);
      3'd3:       return !(v >= -1048576 && v <= 1048575) || (v % 2 != 0);
      3'd4:       return (imm % 4096) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_instr(input logic [2:0] src, input logic [31:0] imm,
      input logic [31:0] op, input logic [31:0] d, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] f);
    case (src)
      3'd0: return ((imm & 32'hFFF) << 20) | (a << 15) | (f << 12) | (d << 7) | op;
      3'd1: return (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
                   | ((imm & 32'h1F) << 7) | op;
      3'd2: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20)
                   | (a << 15) | (f << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 1) << 7) | op;
      3'd3: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (d << 7) | op;
      3'd4: return (imm & 32'hFFFF_F000) | (d << 7) | op;
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Independent immediate-extend decoder as a core would apply it.
  function automatic logic [31:0] decode(input logic [2:0] src, input logic [31:0] i);
    case (src)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'h0};
    endcase
  endfunction

  task automatic monitor();
    exp_t e;
    check("pkt_count", 32'(pkt_count), sat(m_pkt, 65535));
    check("err_count", 32'(err_count), sat(m_err, 65535));
    check("pkt_count_sat", 32'(pkt_count2), sat(m_pkt, 3));
    check("err_count_sat", 32'(err_count2), sat(m_err, 3));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("instr", instr, e.instr);
        check("out_err", 32'(out_err), 32'(e.err));
        if (!e.err) check("imm_decode", decode(e.src, instr), e.imm);
        m_pkt++;
        if (e.err) m_err++;
      end
    end
    if (in_valid && in_ready) begin
      e.src   = immsrc;
      e.imm   = immval;
      e.err   = model_err(immsrc, immval);
      e.instr = model_instr(immsrc, immval, 32'(opcode), 32'(rd), 32'(rs1), 32'(rs2),
                            32'(funct3));
      sb.push_back(e);
      m_acc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] imm, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] a, input logic [4:0] b, input logic [2:0] f);
    in_valid = 1'b1; immsrc = s; immval = imm; opcode = op;
    rd = d; rs1 = a; rs2 = b; funct3 = f;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] tbl [13];
    tbl = '{32'h7FF, 32'hFFFF_F800, 32'h800, 32'hFFFF_F7FF, 32'hFFE, 32'hFFF,
            32'hFFFF_F000, 32'h1000, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000,
            32'h0000_1000, 32'h0};
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return tbl[$urandom_range(0, 12)];
      3: return $urandom << 12;
      4: return 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
      default: return 32'($urandom_range(0, 127)) << 1;
    endcase
  endfunction

  initial begin
    int pkt_before;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_pkt", 32'(pkt_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // I-type latency: visible two cycles after the accepting cycle.
    out_ready = 1'b1;
    drive(3'b000, 32'hFFFF_FFFF, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0);
    tick();
    in_valid = 1'b0;
    check("lat_c1_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_c2_out_valid", 32'(out_valid), 32'd1);
    check("lat_c2_instr", instr, 32'hFFF0_0093);
    drain("drain_i");

    drive(3'b010, 32'h8, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0);
    tick();
    drive(3'b010, 32'h9, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0);
    tick();
    drain("drain_b");
    check("b_err_count", 32'(err_count), 32'd1);

    drive(3'b100, 32'h1234_5000, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0);
    tick();
    drive(3'b000, 32'h800, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0);
    tick();
    drive(3'b110, 32'h0, 7'h7F, 5'd3, 5'd3, 5'd3, 3'd7);
    tick();
    drain("drain_u");

    // Backpressure: third request must stall until the consumer frees a slot.
    pkt_before = m_pkt;
    out_ready = 1'b0;
    drive(3'b000, 32'h1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0); tick();
    drive(3'b000, 32'h2, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0); tick();
    drive(3'b000, 32'h3, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    check("bp_accepted", 32'(sb.size()), 32'd2);
    out_ready = 1'b1;
    begin
      int acc0;
      acc0 = m_acc;
      for (int k = 0; k < 10 && m_acc == acc0; k++) tick();
    end
    drain("drain_bp");
    check("bp_pkt_count", 32'(pkt_count), 32'(pkt_before + 3));

    // Asynchronous reset with two requests in flight.
    out_ready = 1'b0;
    drive(3'b100, 32'hABCD_E000, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0); tick();
    drive(3'b100, 32'h0000_1000, 7'h37, 5'd8, 5'd0, 5'd0, 3'd0); tick();
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_pkt", 32'(pkt_count), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    sb.delete();
    m_pkt = 0;
    m_err = 0;
    tick();
    rst = 1'b0;
    #1;
    check("rerst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("rerst_idle_out_valid", 32'(out_valid), 32'd0);

    // Five deliveries saturate the 2-bit counter at 3.
    for (int k = 0; k < 5; k++) begin
      drive(3'b000, 32'(k), 7'h13, 5'(k), 5'd0, 5'd0, 3'd0);
      tick();
    end
    drain("drain_sat");
    check("sat_pkt_count2", 32'(pkt_count2), 32'd3);
    check("sat_pkt_count", 32'(pkt_count), 32'd5);

    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      immsrc    = 3'($urandom_range(0, 7));
      immval    = rand_imm();
      opcode    = 7'($urandom_range(0, 127));
      rd        = 5'($urandom_range(0, 31));
      rs1       = 5'($urandom_range(0, 31));
      rs2       = 5'($urandom_range(0, 31));
      funct3    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain("drain_rand");

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
